// File: rtl/flow_speed_ctrl_if.sv
// Control-side signal bundle for the flow-LED speed controller.
// The master drives the raw button and the run enable. The slave (the
// controller) returns the step strobe, the speed index and the press strobe.
interface flow_speed_ctrl_if;
  logic       key_n;      // raw push-button, 0 = pressed, asynchronous to clk
  logic       en;         // 1 = run the step generator, 0 = hold
  logic       step;       // one-cycle strobe per elapsed period
  logic [1:0] speed_sel;  // current speed index 0..3
  logic       key_press;  // one-cycle strobe per accepted press

  modport master (
    output key_n,
    output en,
    input  step,
    input  speed_sel,
    input  key_press
  );

  modport slave (
    input  key_n,
    input  en,
    output step,
    output speed_sel,
    output key_press
  );
endinterface

// File: rtl/flow_speed_ctrl.sv
// Upstream control stage for the flow-LED shifter.
// The block synchronises and debounces one active-low push-button. Each
// accepted press advances a 2-bit speed index, which selects one of four step
// periods. A registered single-cycle step strobe is produced once per period.
module flow_speed_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PERIOD0         = 25_000_000,
  parameter int unsigned PERIOD1         = 12_500_000,
  parameter int unsigned PERIOD2         = 6_250_000,
  parameter int unsigned PERIOD3         = 3_125_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  flow_speed_ctrl_if.slave  bus
);

  // Terminal counts for the debounce and period counters, at counter width.
  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P0_TC  = CNT_W'(PERIOD0 - 1);
  localparam logic [CNT_W-1:0] P1_TC  = CNT_W'(PERIOD1 - 1);
  localparam logic [CNT_W-1:0] P2_TC  = CNT_W'(PERIOD2 - 1);
  localparam logic [CNT_W-1:0] P3_TC  = CNT_W'(PERIOD3 - 1);

  // Button path.
  logic             s1;        // first synchroniser stage
  logic             s2;        // second synchroniser stage, safe to use
  logic             deb;       // debounced level, 1 = released
  logic             deb_q;     // debounced level one cycle later
  logic [CNT_W-1:0] deb_cnt;   // cycles that s2 has disagreed with deb

  // Speed and step path.
  logic [CNT_W-1:0] cnt;       // period counter
  logic [CNT_W-1:0] period_tc; // terminal count for the selected speed
  logic             press;     // deb fell on the previous edge
  logic             step_r;
  logic             key_press_r;
  logic [1:0]       speed_sel_r;

  // Two-flop synchroniser. Both stages reset to the released level, so a key
  // held through reset is seen as a fresh press once reset is removed.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge. Blocking assignments here would let s2 pick
  // up the new s1 in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.key_n;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after it has been stable for
  // DEBOUNCE_CYCLES consecutive cycles. Any return to the current level
  // restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else if (s2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_TC) begin
      deb     <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level. It is used to find the press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b1;
    end else begin
      deb_q <= deb;
    end
  end

  // A press is the 1->0 transition of the debounced level. A release
  // (0->1) is intentionally not reported.
  assign press = deb_q & ~deb;

  // Select the terminal count for the current speed index.
  // NOTE: every output of a combinational block gets a default first. This
  // means no path can leave it unassigned and infer a latch.
  always_comb begin
    period_tc = P0_TC;
    unique case (speed_sel_r)
      2'd0: period_tc = P0_TC;
      2'd1: period_tc = P1_TC;
      2'd2: period_tc = P2_TC;
      2'd3: period_tc = P3_TC;
      default: period_tc = P0_TC;
    endcase
  end

  // Speed selection and step generation.
  // A press takes priority over a terminal count on the same edge. The new
  // period then starts cleanly from zero and no stale strobe is emitted.
  // While disabled, the counter is held at zero, so the first enabled period
  // is a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      step_r      <= 1'b0;
      key_press_r <= 1'b0;
      speed_sel_r <= 2'd0;
    end else if (press) begin
      cnt         <= '0;
      step_r      <= 1'b0;
      key_press_r <= 1'b1;
      speed_sel_r <= speed_sel_r + 2'd1;
    end else if (!bus.en) begin
      cnt         <= '0;
      step_r      <= 1'b0;
      key_press_r <= 1'b0;
    end else if (cnt == period_tc) begin
      cnt         <= '0;
      step_r      <= 1'b1;
      key_press_r <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      step_r      <= 1'b0;
      key_press_r <= 1'b0;
    end
  end

  assign bus.step      = step_r;
  assign bus.key_press = key_press_r;
  assign bus.speed_sel = speed_sel_r;

endmodule
